// File: rtl/sync_fifo_if.sv
// Handshake/status bundle for sync_fifo. The producer/consumer side uses
// the master modport and the FIFO uses the slave modport.
interface sync_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, data_in, rd_en, clr_err,
    input  data_out, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

  modport slave (
    input  wr_en, data_in, rd_en, clr_err,
    output data_out, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock parametrised FIFO with registered or first-word-fall-through
// read, programmable almost thresholds, occupancy count and sticky errors.
//
// Handshake: a write is taken on a rising edge when wr_en=1 and full=0; a
// read (pop) is taken when rd_en=1 and empty=0. full/empty act as the
// not-ready indications, are decoded from the registered count only and never
// depend on wr_en/rd_en in the same cycle. A request made against a blocking
// flag is dropped (no state change) and raises the matching sticky error.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH  = (2 ** ADDR_WIDTH) - 2,
  parameter int AE_THRESH  = 2,
  parameter bit FWFT       = 1'b0
) (
  input logic        clk,
  input logic        rst_n,
  sync_fifo_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AF_T    = AF_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_T    = AE_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  overflow_q;
  logic                  underflow_q;
  logic                  full_w;
  logic                  empty_w;
  logic                  wr_acc;
  logic                  rd_acc;

  // Status flags come from the registered count alone.
  always_comb begin
    full_w  = (count_q == DEPTH_C);
    empty_w = (count_q == '0);
    wr_acc  = bus.wr_en & ~full_w;
    rd_acc  = bus.rd_en & ~empty_w;
  end

  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (count_q >= AF_T);
  assign bus.almost_empty = (count_q <= AE_T);
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

  // Storage is not reset; a write landing while reset is held is suppressed.
  always_ff @(posedge clk) begin
    if (wr_acc && rst_n) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  // Pointers, occupancy and sticky error flags (set beats clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
      overflow_q  <= (bus.wr_en & full_w)  | (overflow_q  & ~bus.clr_err);
      underflow_q <= (bus.rd_en & empty_w) | (underflow_q & ~bus.clr_err);
    end
  end

  generate
    if (FWFT == 1'b0) begin : g_reg_read
      logic [DATA_WIDTH-1:0] dout_q;
      // Registered read: load the head entry on each accepted pop.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dout_q <= '0;
        end else if (rd_acc) begin
          dout_q <= mem[rd_ptr];
        end
      end
      assign bus.data_out = dout_q;
    end else begin : g_fwft_read
      // Fall-through: head entry is shown directly, zero when empty.
      assign bus.data_out = empty_w ? '0 : mem[rd_ptr];
    end
  endgenerate
endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: one registered-read instance and one
// first-word-fall-through instance share clock and reset.
module tb_sync_fifo;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [7:0] exp_q[$];

  sync_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) i0 ();
  sync_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) i1 ();

  sync_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AF_THRESH(14), .AE_THRESH(2),
              .FWFT(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(i0));
  sync_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AF_THRESH(14), .AE_THRESH(2),
              .FWFT(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(i1));

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks for the registered-read instance
  task automatic push(input logic [7:0] d);
    i0.wr_en = 1'b1; i0.data_in = d;
    tick();
    i0.wr_en = 1'b0;
  endtask

  task automatic pop();
    i0.rd_en = 1'b1;
    tick();
    i0.rd_en = 1'b0;
  endtask

  task automatic push_pop(input logic [7:0] d);
    i0.wr_en = 1'b1; i0.rd_en = 1'b1; i0.data_in = d;
    tick();
    i0.wr_en = 1'b0; i0.rd_en = 1'b0;
  endtask

  task automatic clear();
    i0.clr_err = 1'b1;
    tick();
    i0.clr_err = 1'b0;
  endtask

  initial begin
    int n;
    int next_w;
    int cyc;
    logic do_w;
    logic do_r;
    logic [7:0] d;
    logic [7:0] exp_d;

    checks = 0; errors = 0;
    rst_n = 1'b0;
    i0.wr_en = 0; i0.rd_en = 0; i0.clr_err = 0; i0.data_in = '0;
    i1.wr_en = 0; i1.rd_en = 0; i1.clr_err = 0; i1.data_in = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    check("rst_count", i0.count, 0);
    check("rst_empty", i0.empty, 1);
    check("rst_ae", i0.almost_empty, 1);
    check("rst_full", i0.full, 0);
    check("rst_af", i0.almost_full, 0);
    check("rst_ovf", i0.overflow, 0);
    check("rst_unf", i0.underflow, 0);
    check("rst_dout0", i0.data_out, 8'h00);
    check("rst_dout1", i1.data_out, 8'h00);

    // Asynchronous reset mid-operation
    push(8'h11); push(8'h22); push(8'h33);
    check("pre_rst_count", i0.count, 3);
    pop();
    check("pre_rst_dout", i0.data_out, 8'h11);
    #2 rst_n = 1'b0;
    #1;
    check("async_count", i0.count, 0);
    check("async_empty", i0.empty, 1);
    check("async_ae", i0.almost_empty, 1);
    check("async_full", i0.full, 0);
    check("async_af", i0.almost_full, 0);
    check("async_dout", i0.data_out, 8'h00);
    #1 rst_n = 1'b1;
    pop();
    check("post_rst_unf", i0.underflow, 1);
    check("post_rst_count", i0.count, 0);
    clear();
    check("unf_cleared", i0.underflow, 0);

    // Registered read ordering
    push(8'hAA); push(8'h55);
    check("ord_count", i0.count, 2);
    check("ord_dout_hold", i0.data_out, 8'h00);
    i0.rd_en = 1'b1;
    tick();
    check("ord_first", i0.data_out, 8'hAA);
    tick();
    i0.rd_en = 1'b0;
    check("ord_second", i0.data_out, 8'h55);
    check("ord_empty", i0.empty, 1);
    check("ord_count_end", i0.count, 0);

    // Fill to full, overflow, drain in order
    for (int i = 0; i < 16; i++) begin
      d = 8'($urandom_range(0, 255));
      exp_q.push_back(d);
      push(d);
      n = i + 1;
      check("fill_count", i0.count, n);
      check("fill_af", i0.almost_full, (n >= 14) ? 1 : 0);
      check("fill_full", i0.full, (n == 16) ? 1 : 0);
      check("fill_ae", i0.almost_empty, (n <= 2) ? 1 : 0);
    end
    push(8'hEE);
    check("ovf_count", i0.count, 16);
    check("ovf_flag", i0.overflow, 1);
    check("ovf_full", i0.full, 1);
    for (int i = 0; i < 16; i++) begin
      exp_d = exp_q.pop_front();
      pop();
      check("drain_data", i0.data_out, exp_d);
      check("drain_count", i0.count, 15 - i);
    end
    check("drain_empty", i0.empty, 1);
    check("drain_ovf_sticky", i0.overflow, 1);
    clear();
    check("ovf_cleared", i0.overflow, 0);

    // Simultaneous read and write
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(8'(8'h50 + i));
      push(8'(8'h50 + i));
    end
    push_pop(8'h60);
    exp_d = exp_q.pop_front();
    exp_q.push_back(8'h60);
    check("sim_mid_count", i0.count, 5);
    check("sim_mid_data", i0.data_out, exp_d);
    for (int i = 0; i < 11; i++) begin
      exp_q.push_back(8'(8'h70 + i));
      push(8'(8'h70 + i));
    end
    check("sim_full", i0.full, 1);
    push_pop(8'h99);
    exp_d = exp_q.pop_front();
    check("sim_full_count", i0.count, 15);
    check("sim_full_ovf", i0.overflow, 1);
    check("sim_full_data", i0.data_out, exp_d);
    while (exp_q.size() > 0) begin
      exp_d = exp_q.pop_front();
      pop();
      check("sim_drain", i0.data_out, exp_d);
    end
    check("sim_drain_empty", i0.empty, 1);
    clear();
    push_pop(8'hC3);
    check("sim_empty_count", i0.count, 1);
    check("sim_empty_unf", i0.underflow, 1);
    pop();
    check("sim_empty_data", i0.data_out, 8'hC3);
    i0.rd_en = 1'b1; i0.clr_err = 1'b1;
    tick();
    i0.rd_en = 1'b0; i0.clr_err = 1'b0;
    check("set_wins", i0.underflow, 1);
    clear();
    check("unf_clear2", i0.underflow, 0);

    // Wrap-around with random-gap reads
    next_w = 0;
    cyc = 0;
    while ((next_w < 40 || exp_q.size() > 0) && cyc < 400) begin
      do_w = (next_w < 40) && (exp_q.size() < 16) && ($urandom_range(0, 3) != 0);
      do_r = (exp_q.size() > 0) && ((next_w >= 40) || ($urandom_range(0, 2) == 0));
      exp_d = 8'h00;
      if (do_r) exp_d = exp_q.pop_front();
      if (do_w) exp_q.push_back(8'(next_w));
      i0.wr_en = do_w; i0.rd_en = do_r; i0.data_in = 8'(next_w);
      tick();
      i0.wr_en = 1'b0; i0.rd_en = 1'b0;
      if (do_w) next_w++;
      if (do_r) check("wrap_data", i0.data_out, exp_d);
      check("wrap_count", i0.count, exp_q.size());
      cyc++;
    end
    check("wrap_done", i0.empty, 1);
    check("wrap_writes", next_w, 40);

    // First-word-fall-through instance
    check("fwft_idle_empty", i1.empty, 1);
    i1.wr_en = 1'b1; i1.data_in = 8'h3C;
    tick();
    check("fwft_first", i1.data_out, 8'h3C);
    check("fwft_not_empty", i1.empty, 0);
    i1.data_in = 8'h7E;
    tick();
    i1.wr_en = 1'b0;
    check("fwft_head_hold", i1.data_out, 8'h3C);
    i1.rd_en = 1'b1;
    tick();
    check("fwft_second", i1.data_out, 8'h7E);
    tick();
    i1.rd_en = 1'b0;
    check("fwft_empty", i1.empty, 1);
    check("fwft_zero", i1.data_out, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised FIFO. It is the next generation of the team's FIFO family and buffers data between producer and consumer logic in the same clock domain. Compared with the earlier FIFO, it adds:
- configurable width and depth,
- a selectable first-word-fall-through (FWFT) read mode,
- programmable almost-full and almost-empty thresholds,
- an occupancy count,
- sticky overflow and underflow error flags.

## Interface
- DATA_WIDTH, 8, width of each data word.
- ADDR_WIDTH, 4, log2 of the depth; DEPTH = 2**ADDR_WIDTH.
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH.
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-1.
- FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through.

- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- wr_en  in  1  write request.
- data_in  in  DATA_WIDTH  write data.
- rd_en  in  1  read (pop) request.
- clr_err  in  1  synchronous clear of overflow and underflow.
- data_out  out  DATA_WIDTH  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.

## Operation
Accept conditions:
- wr_acc = wr_en & ~full.
- rd_acc = rd_en & ~empty.
- Acceptance is evaluated on the pre-edge state.

Storage and pointers:
- Storage is a DEPTH x DATA_WIDTH array and is not reset.
- wr_ptr and rd_ptr are ADDR_WIDTH bits wide and wrap modulo DEPTH with no special case.
- On wr_acc: mem[wr_ptr] <= data_in, then wr_ptr increments.
- On rd_acc: rd_ptr increments.

Count update:
- count increments on wr_acc only.
- count decrements on rd_acc only.
- count is unchanged when both or neither are accepted.

Simultaneous requests:
- When full, with wr_en and rd_en both high: the read is accepted and the write is rejected. count becomes DEPTH-1 and overflow sets.
- When empty, with wr_en and rd_en both high: the write is accepted and the read is rejected. count becomes 1 and underflow sets.

Status flags:
- full, empty, almost_full and almost_empty are decoded combinationally from the registered count only.
- They are never derived from the wr_en or rd_en inputs.

Error flags:
- overflow sets on wr_en & full; underflow sets on rd_en & empty.
- Both are cleared by clr_err.
- If set and clear occur in the same cycle, set wins.
- A rejected request modifies neither memory, the pointers nor count.

Read modes:
- FWFT=0: data_out is a register loaded with mem[rd_ptr] on rd_acc and held otherwise.
- FWFT=1: data_out = empty ? 0 : mem[rd_ptr], a combinational view of the head entry. rd_acc pops the head, and the next entry (or 0) appears after the edge.

## Timing
Reset values (asserting rst_n low forces all of these immediately, including mid-operation; no pending write completes):
- count = 0, wr_ptr = 0, rd_ptr = 0.
- empty = 1, almost_empty = 1.
- full = 0, almost_full = 0.
- overflow = 0, underflow = 0.
- data_out = 0 in both modes.

Write latency:
- Data written at edge N is readable from edge N onward.
- empty deasserts and count updates after edge N.

FWFT=0 read latency:
- rd_acc at edge N makes the word valid on data_out after edge N.
- The word is visible in the cycle following the request cycle and holds until the next rd_acc.

FWFT=1 read latency:
- A write into an empty FIFO at edge N makes the word visible on data_out after edge N.
- This is zero added latency.

General timing:
- Throughput is one write and one read per cycle, sustained indefinitely.
- Flag transitions coincide with the count change: full asserts on the edge that accepts the DEPTH-th word, and deasserts on the edge of the next rd_acc.

## Test plan
All scenarios use DATA_WIDTH=8, ADDR_WIDTH=4, AF_THRESH=14, AE_THRESH=2 unless stated otherwise.
- Reset: write 3 words, then pulse rst_n low between edges -> immediately count=0, empty=1, almost_empty=1, data_out=0x00, all other flags 0; a subsequent read sets underflow=1.
- FWFT=0 ordering: write 0xAA then 0x55, then assert rd_en for 2 cycles -> data_out=0xAA after the first read edge and 0x55 after the second; empty=1 and count=0 at the end.
- Fill and overflow: write 16 random words -> almost_full asserts at count=14, full at count=16, almost_empty deasserts at count=3; a 17th write leaves count=16 and sets overflow=1; draining returns the 16 words in order; clr_err clears overflow.
- Simultaneous events: rd_en+wr_en at count=5 -> count stays 5; at full -> count=15 and overflow=1; at empty -> count=1, underflow=1, and the written word is the next read.
- Wrap-around: interleave 40 writes of an incrementing pattern (0x00..0x27) with random-gap reads, keeping count between 0 and 16 -> every read matches the scoreboard and the pointers wrap at least twice.
- FWFT=1: write 0x3C into an empty FIFO -> after that edge data_out=0x3C and empty=0; write 0x7E then rd_en -> data_out=0x7E; a further rd_en leaves empty=1 and data_out=0x00.
